// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and decodes every datapath
// select, strobe and the ALU operation code from the current state.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  state_e     dec_s;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       pc_write;
  logic       branch;

  assign state = state_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) state_q <= state_e'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // R-type function decode to ALU code, plus legality for writeback.
  always_comb begin
    funct_alu = 3'b010;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Output decode; reset shows FETCH selects with every strobe suppressed.
  always_comb begin
    dec_s      = reset ? FETCH : state_q;
    alu_op     = 3'b010;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (dec_s)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: retire = 1'b0;
          default:                                       retire = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMREAD:  iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = funct_alu;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = funct_ok;
        retire    = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b110;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & zero);
    if (reset) begin
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: each scenario pushes the
// expected per-cycle output vectors into a scoreboard, then pops and compares
// one vector per cycle on the falling edge.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       pc_en, retire;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       iord;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       pcen;
    logic       ret;
  } obs_t;

  obs_t sb_q[$];
  obs_t act;
  obs_t exp_v;
  int   n_tests = 0;
  int   n_fail  = 0;

  assign act = {state, alu_op, alu_src_a, alu_src_b, pc_src, iord, ir_write,
                mem_write, reg_write, reg_dst, mem_to_reg, pc_en, retire};

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .iord(iord), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_en(pc_en), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] st, input logic [2:0] aop,
                              input logic sa, input logic [1:0] sb,
                              input logic [1:0] ps, input logic io,
                              input logic irw, input logic mw, input logic rw,
                              input logic rd, input logic m2r,
                              input logic pcen, input logic ret);
    return {st, aop, sa, sb, ps, io, irw, mw, rw, rd, m2r, pcen, ret};
  endfunction

  // Expected vectors written out literally from the state table.
  function automatic obs_t e_fetch();    return mk(4'd0, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0); endfunction
  function automatic obs_t e_decode();   return mk(4'd1, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic obs_t e_memadr();   return mk(4'd2, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

  task automatic drain(input string name);
    int idx = 0;
    while (sb_q.size() != 0) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s[%0d]: got state=%0d vec=%h, want state=%0d vec=%h",
                 name, idx, act.st, act, exp_v.st, exp_v);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(mk(4'd0, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk(4'd0, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    drain("reset");
    reset = 1'b0;
  endtask

  task automatic test_lw();
    op = 6'b100011; zero = 1'b1;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(e_memadr());
    sb_q.push_back(mk(4'd3, 3'b010, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk(4'd4, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 1));
    drain("lw");
    zero = 1'b0;
  endtask

  task automatic test_sw();
    op = 6'b101011;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(e_memadr());
    sb_q.push_back(mk(4'd5, 3'b010, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1));
    drain("sw");
  endtask

  task automatic run_rtype(input logic [5:0] f, input logic [2:0] aop,
                           input logic rw, input string name);
    op = 6'b000000; funct = f;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(mk(4'd6, aop, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk(4'd7, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, rw, 1, 0, 0, 1));
    drain(name);
  endtask

  task automatic test_rtype();
    run_rtype(6'b100000, 3'b010, 1'b1, "rtype_add");
    run_rtype(6'b100100, 3'b000, 1'b1, "rtype_and");
    run_rtype(6'b100101, 3'b001, 1'b1, "rtype_or");
    run_rtype(6'b000000, 3'b010, 1'b0, "rtype_bad0");
    run_rtype(6'b111111, 3'b010, 1'b0, "rtype_bad3f");
  endtask

  task automatic test_back_to_back();
    run_rtype(6'b100010, 3'b110, 1'b1, "b2b_sub");
    run_rtype(6'b101010, 3'b111, 1'b1, "b2b_slt");
  endtask

  task automatic run_beq(input logic z, input string name);
    op = 6'b000100;
    // zero is held low until the BEQ cycle itself to show it is used live.
    zero = 1'b0;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    drain(name);
    zero = z;
    sb_q.push_back(mk(4'd8, 3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, z, 1));
    drain(name);
    zero = 1'b0;
  endtask

  task automatic test_beq();
    run_beq(1'b1, "beq_taken");
    run_beq(1'b0, "beq_not_taken");
  endtask

  task automatic test_addi();
    op = 6'b001000;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(mk(4'd9, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk(4'd10, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1));
    drain("addi");
  endtask

  task automatic test_jump();
    op = 6'b000010;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(mk(4'd11, 3'b010, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 1));
    drain("jump");
  endtask

  task automatic test_unsupported();
    op = 6'b111111;
    sb_q.push_back(e_fetch());
    sb_q.push_back(mk(4'd1, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    sb_q.push_back(e_fetch());
    drain("unsupported");
    // That FETCH was consumed; finish the following instruction as a jump.
    op = 6'b000010;
    sb_q.push_back(e_decode());
    sb_q.push_back(mk(4'd11, 3'b010, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 1));
    drain("after_unsupported");
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    sb_q.push_back(e_fetch());
    sb_q.push_back(e_decode());
    sb_q.push_back(e_memadr());
    drain("rst_memread_pre");
    reset = 1'b1;
    sb_q.push_back(mk(4'd3, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    drain("rst_memread");
    reset = 1'b0;
    sb_q.push_back(e_fetch());
    drain("rst_memread_post");
    // Reset in MEMWRITE must suppress the write strobe.
    op = 6'b101011;
    sb_q.push_back(e_decode());
    sb_q.push_back(e_memadr());
    drain("rst_memwrite_pre");
    reset = 1'b1;
    sb_q.push_back(mk(4'd5, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    drain("rst_memwrite");
    reset = 1'b0;
    sb_q.push_back(e_fetch());
    drain("rst_memwrite_post");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_back_to_back();
    test_beq();
    test_addi();
    test_jump();
    test_unsupported();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU operation code directly, using the ALU encoding AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Consumes the ALU zero flag to resolve beq.
- Also drives all datapath mux selects and write enables.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must not be changed from 0 in the base design.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag
- alu_op  out  3  ALU operation code
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=register B, 01=constant 4, 10=sign-extended imm, 11=imm<<2
- pc_src  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  instruction register load
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=memory data
- pc_en  out  1  PC load = pc_write | (branch & zero)
- retire  out  1  one-cycle pulse in the final cycle of every instruction
- state  out  4  current state code, for debug and bench

Behaviour:
- Single 4-bit state register.
- All outputs are combinational decodes of the current state; alu_op also uses funct in EXECUTE, and pc_en also uses zero.
- Reset:
  - reset high at a rising edge sets state=FETCH (0).
  - While reset is high, ir_write, pc_en, mem_write, reg_write and retire are forced to 0.
  - Other outputs show their FETCH values.
  - Reset mid-instruction abandons the instruction; no write strobe fires in the reset cycle.
- Output defaults in every state: all strobes and selects 0, alu_op=010.
- States, codes and non-default outputs:
  - FETCH=0: alu_src_b=01, ir_write=1, pc_write=1. Next: DECODE.
  - DECODE=1: alu_src_b=11 (branch target into ALUOut). Next by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BEQ
    - 001000 (addi) -> ADDIEXEC
    - 000010 (j) -> JUMP
    - any other op -> FETCH, with retire=1 (executes as a NOP)
  - MEMADR=2: alu_src_a=1, alu_src_b=10. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD=3: iord=1. Next: MEMWB.
  - MEMWB=4: mem_to_reg=1, reg_write=1, retire=1. Next: FETCH.
  - MEMWRITE=5: iord=1, mem_write=1, retire=1. Next: FETCH.
  - EXECUTE=6: alu_src_a=1, alu_src_b=00; alu_op from funct. Next: ALUWB.
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - other -> 010
  - ALUWB=7: reg_dst=1, retire=1; reg_write=1 only if funct is one of the five legal codes. Next: FETCH.
  - BEQ=8: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, branch=1, retire=1. Next: FETCH.
  - ADDIEXEC=9: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
  - ADDIWB=10: reg_write=1, retire=1. Next: FETCH.
  - JUMP=11: pc_src=10, pc_write=1, retire=1. Next: FETCH.
  - Codes 12-15 are illegal and go to FETCH on the next edge with all strobes 0.
- Latency in cycles, from FETCH to the retire cycle inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unsupported op 2
- op and funct are sampled every cycle; the datapath holds them stable from the cycle after FETCH until the next FETCH.
- pc_en is asserted in BEQ only when zero=1; zero is evaluated in that same cycle.

Test Plan:
- Reset: reset=1 for 2 cycles in any state -> state=0, and ir_write/pc_en/reg_write/mem_write/retire all 0 during reset. First cycle after release shows ir_write=1, pc_en=1, alu_src_b=01, alu_op=010.
- lw (op=100011) -> states 0,1,2,3,4.
  - Cycle 3: iord=1.
  - Cycle 4: reg_write=1, mem_to_reg=1, retire=1.
  - Then returns to 0.
- sw (op=101011) -> states 0,1,2,5, with mem_write=1 only in state 5; never reg_write.
- R-type, funct = 100010 then 101010 in consecutive instructions -> EXECUTE alu_op = 110 then 111. ALUWB has reg_dst=1, reg_write=1.
- R-type with funct=000000 -> EXECUTE alu_op=010 and ALUWB reg_write=0, but retire=1.
- beq (op=000100) in two runs:
  - zero=1 in BEQ -> pc_en=1, pc_src=01, alu_op=110.
  - zero=0 -> pc_en=0.
  - Both runs take 3 cycles.
- j (op=000010) -> state 11 with pc_src=10, pc_en=1.
- Unsupported op=111111 -> DECODE then FETCH with retire=1 in DECODE.
- Reset asserted during MEMREAD -> no reg_write; next state is 0.
